// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: FSM states, ALU codes,
// opcodes and datapath select codes.
package rv_ctrl_pkg;

  localparam logic [3:0] StFetch    = 4'd0;
  localparam logic [3:0] StDecode   = 4'd1;
  localparam logic [3:0] StMemAdr   = 4'd2;
  localparam logic [3:0] StMemRead  = 4'd3;
  localparam logic [3:0] StMemWb    = 4'd4;
  localparam logic [3:0] StMemWrite = 4'd5;
  localparam logic [3:0] StExecR    = 4'd6;
  localparam logic [3:0] StExecI    = 4'd7;
  localparam logic [3:0] StAluWb    = 4'd8;
  localparam logic [3:0] StBranch   = 4'd9;
  localparam logic [3:0] StJal      = 4'd10;
  localparam logic [3:0] StIllegal  = 4'd11;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSll = 3'b001;
  localparam logic [2:0] AluSub = 3'b010;
  localparam logic [2:0] AluXor = 3'b100;
  localparam logic [2:0] AluSrl = 3'b101;
  localparam logic [2:0] AluOr  = 3'b110;
  localparam logic [2:0] AluAnd = 3'b111;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam logic [1:0] ResAluOut = 2'b00;
  localparam logic [1:0] ResMem    = 2'b01;
  localparam logic [1:0] ResAlu    = 2'b10;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARs1   = 2'b10;

  localparam logic [1:0] SrcBRs2   = 2'b00;
  localparam logic [1:0] SrcBImm   = 2'b01;
  localparam logic [1:0] SrcBFour  = 2'b10;

  localparam logic [2:0] ImmI = 3'b000;
  localparam logic [2:0] ImmS = 3'b001;
  localparam logic [2:0] ImmB = 3'b010;
  localparam logic [2:0] ImmJ = 3'b011;

endpackage

// File: rtl/rv_alu_dec.sv
// ALU operation decoder for R-type and I-type ALU instructions; flags encodings
// this core does not implement (slt/sltu, arithmetic shifts, stray funct7 bits).
module rv_alu_dec
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [2:0] alu_sel,
  output logic       alu_illegal
);

  logic is_r;
  logic is_alu;

  assign is_r   = (opcode == OpRType);
  assign is_alu = is_r || (opcode == OpIType);

  always_comb begin
    alu_sel     = AluAdd;
    alu_illegal = 1'b0;
    if (is_alu) begin
      case (funct3)
        3'b000:  alu_sel = (is_r && funct7_5) ? AluSub : AluAdd;
        3'b001:  alu_sel = AluSll;
        3'b100:  alu_sel = AluXor;
        3'b101:  alu_sel = AluSrl;
        3'b110:  alu_sel = AluOr;
        3'b111:  alu_sel = AluAnd;
        default: alu_illegal = 1'b1;
      endcase
      // On I-type only srai uses instr[30]; on R-type only sub/sra may set it.
      if (funct3 == 3'b101 && funct7_5) alu_illegal = 1'b1;
      if (is_r && funct7_5 && funct3 != 3'b000 && funct3 != 3'b101) alu_illegal = 1'b1;
    end
  end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// and drives the datapath selects and write strobes from the registered state.
module rv_multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter logic [3:0] RESET_STATE  = 4'd0,
  parameter bit         ILLEGAL_TRAP = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zf,
  input  logic       sf,
  output logic       pc_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_sel,
  output logic [2:0] imm_src,
  output logic       illegal,
  output logic [3:0] state_o
);

  logic [3:0] state_q, state_d;
  logic [2:0] dec_alu_sel;
  logic       dec_illegal;
  logic       br_legal;
  logic       br_taken;

  rv_alu_dec u_alu_dec (
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7_5    (funct7_5),
    .alu_sel     (dec_alu_sel),
    .alu_illegal (dec_illegal)
  );

  // Signed overflow is deliberately ignored: blt/bge use SF alone.
  always_comb begin
    br_legal = 1'b1;
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = zf;
      3'b001:  br_taken = ~zf;
      3'b100:  br_taken = sf;
      3'b101:  br_taken = ~sf;
      default: br_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:    state_d = StDecode;
      StDecode: begin
        case (opcode)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRType:         state_d = dec_illegal ? StIllegal : StExecR;
          OpIType:         state_d = dec_illegal ? StIllegal : StExecI;
          OpBranch:        state_d = br_legal ? StBranch : StIllegal;
          OpJal:           state_d = StJal;
          default:         state_d = StIllegal;
        endcase
      end
      StMemAdr:   state_d = (opcode == OpLoad) ? StMemRead : StMemWrite;
      StMemRead:  state_d = StMemWb;
      StExecR,
      StExecI,
      StJal:      state_d = StAluWb;
      StIllegal:  state_d = ILLEGAL_TRAP ? StIllegal : StFetch;
      default:    state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= RESET_STATE;
    else     state_q <= state_d;
  end

  always_comb begin
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    result_src = ResAluOut;
    alu_src_a  = SrcAPc;
    alu_src_b  = SrcBRs2;
    alu_sel    = AluAdd;
    illegal    = 1'b0;
    case (state_q)
      StFetch: begin
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        alu_src_b  = SrcBFour;
        result_src = ResAlu;
      end
      StDecode: begin
        alu_src_a = SrcAOldPc;
        alu_src_b = SrcBImm;
      end
      StMemAdr: begin
        alu_src_a = SrcARs1;
        alu_src_b = SrcBImm;
      end
      StMemRead:  adr_src = 1'b1;
      StMemWb: begin
        result_src = ResMem;
        reg_write  = 1'b1;
      end
      StMemWrite: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      StExecR: begin
        alu_src_a = SrcARs1;
        alu_sel   = dec_alu_sel;
      end
      StExecI: begin
        alu_src_a = SrcARs1;
        alu_src_b = SrcBImm;
        alu_sel   = dec_alu_sel;
      end
      StAluWb:    reg_write = 1'b1;
      StBranch: begin
        alu_src_a = SrcARs1;
        alu_sel   = AluSub;
        pc_write  = br_taken;
      end
      StJal: begin
        alu_src_a = SrcAOldPc;
        alu_src_b = SrcBFour;
        pc_write  = 1'b1;
      end
      StIllegal:  illegal = 1'b1;
      default: ;
    endcase
    // Reset aborts whatever is in flight: no architectural write may land this cycle.
    if (rst) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      illegal   = 1'b0;
    end
  end

  always_comb begin
    case (opcode)
      OpLoad, OpIType: imm_src = ImmI;
      OpStore:         imm_src = ImmS;
      OpBranch:        imm_src = ImmB;
      OpJal:           imm_src = ImmJ;
      default:         imm_src = ImmI;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Bench for rv_multicycle_ctrl: each instruction is expanded into its expected
// per-cycle control script and compared cycle by cycle against the DUT.
module tb_rv_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       zf;
  logic       sf;
  logic       pc_write, adr_src, ir_write, mem_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] alu_sel, imm_src;
  logic [3:0] state_o;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    int st;
    int pcw, irw, mw, rw, adr;
    int rs, a, b, alu, ill;
  } cyc_t;

  cyc_t script[$];
  bit   trapped;

  rv_multicycle_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .funct3     (funct3),
    .funct7_5   (funct7_5),
    .zf         (zf),
    .sf         (sf),
    .pc_write   (pc_write),
    .adr_src    (adr_src),
    .ir_write   (ir_write),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .result_src (result_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_sel    (alu_sel),
    .imm_src    (imm_src),
    .illegal    (illegal),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic cyc_t mk(int st, int pcw, int irw, int mw, int rw, int adr,
                              int rs, int a, int b, int alu, int ill);
    cyc_t c;
    c.st = st; c.pcw = pcw; c.irw = irw; c.mw = mw; c.rw = rw; c.adr = adr;
    c.rs = rs; c.a = a; c.b = b; c.alu = alu; c.ill = ill;
    return c;
  endfunction

  function automatic int exp_imm(logic [6:0] op);
    if (op == 7'b0000011 || op == 7'b0010011) return 0;
    if (op == 7'b0100011) return 1;
    if (op == 7'b1100011) return 2;
    if (op == 7'b1101111) return 3;
    return 0;
  endfunction

  // Mnemonic-level ALU decode: returns ALU code, sets ill for unsupported forms.
  function automatic int exp_alu(bit rtype, logic [2:0] f3, logic f75, output bit ill);
    ill = 0;
    case (f3)
      3'd0: return (rtype && f75) ? 2 : 0;
      3'd1: begin ill = rtype && f75; return 1; end
      3'd4: begin ill = rtype && f75; return 4; end
      3'd5: begin ill = f75;          return 5; end
      3'd6: begin ill = rtype && f75; return 6; end
      3'd7: begin ill = rtype && f75; return 7; end
      default: begin ill = 1; return 0; end
    endcase
  endfunction

  function automatic void push_trap(int hold);
    for (int i = 0; i < hold; i++) script.push_back(mk(11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    trapped = 1;
  endfunction

  function automatic void build(logic [6:0] op, logic [2:0] f3, logic f75, logic z, logic s,
                                int hold);
    bit ill;
    int alu;
    int tk;
    script.delete();
    trapped = 0;
    script.push_back(mk(0, 1, 1, 0, 0, 0, 2, 0, 2, 0, 0));
    script.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    case (op)
      7'b0000011: begin
        script.push_back(mk(2, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
        script.push_back(mk(3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        script.push_back(mk(4, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
      end
      7'b0100011: begin
        script.push_back(mk(2, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
        script.push_back(mk(5, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
      end
      7'b0110011, 7'b0010011: begin
        alu = exp_alu(op == 7'b0110011, f3, f75, ill);
        if (ill) push_trap(hold);
        else begin
          if (op == 7'b0110011) script.push_back(mk(6, 0, 0, 0, 0, 0, 0, 2, 0, alu, 0));
          else                  script.push_back(mk(7, 0, 0, 0, 0, 0, 0, 2, 1, alu, 0));
          script.push_back(mk(8, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        end
      end
      7'b1100011: begin
        case (f3)
          3'd0: tk = z;
          3'd1: tk = !z;
          3'd4: tk = s;
          3'd5: tk = !s;
          default: tk = -1;
        endcase
        if (tk < 0) push_trap(hold);
        else script.push_back(mk(9, tk, 0, 0, 0, 0, 0, 2, 0, 2, 0));
      end
      7'b1101111: begin
        script.push_back(mk(10, 1, 0, 0, 0, 0, 0, 1, 2, 0, 0));
        script.push_back(mk(8, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      end
      default: push_trap(hold);
    endcase
  endfunction

  // One clock cycle: drive rst, compare all outputs at the falling edge.
  task automatic step(input cyc_t e, input bit r);
    rst = r;
    @(negedge clk);
    check("state_o",    int'(state_o),    e.st);
    check("pc_write",   int'(pc_write),   r ? 0 : e.pcw);
    check("ir_write",   int'(ir_write),   r ? 0 : e.irw);
    check("mem_write",  int'(mem_write),  r ? 0 : e.mw);
    check("reg_write",  int'(reg_write),  r ? 0 : e.rw);
    check("illegal",    int'(illegal),    r ? 0 : e.ill);
    check("adr_src",    int'(adr_src),    e.adr);
    check("result_src", int'(result_src), e.rs);
    check("alu_src_a",  int'(alu_src_a),  e.a);
    check("alu_src_b",  int'(alu_src_b),  e.b);
    check("alu_sel",    int'(alu_sel),    e.alu);
    check("imm_src",    int'(imm_src),    exp_imm(opcode));
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                           input logic z, input logic s, input int hold, input int rst_at);
    opcode = op; funct3 = f3; funct7_5 = f75; zf = z; sf = s;
    build(op, f3, f75, z, s, hold);
    for (int i = 0; i < script.size(); i++) begin
      if (i == rst_at) begin
        step(script[i], 1'b1);
        step(script[0], 1'b1);
        return;
      end
      step(script[i], 1'b0);
    end
    if (trapped) step(script[script.size() - 1], 1'b1);
  endtask

  initial begin
    logic [6:0] op;
    int pick;
    rst = 1'b1; opcode = '0; funct3 = '0; funct7_5 = 1'b0; zf = 1'b0; sf = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    step(mk(0, 1, 1, 0, 0, 0, 2, 0, 2, 0, 0), 1'b1);

    run_instr(7'b0100011, 3'd2, 1'b0, 1'b0, 1'b0, 0, 3);   // sw, reset in MEMWRITE
    run_instr(7'b0000011, 3'd2, 1'b0, 1'b0, 1'b0, 0, -1);  // lw
    run_instr(7'b0110011, 3'd0, 1'b1, 1'b0, 1'b0, 0, -1);  // sub
    run_instr(7'b0110011, 3'd4, 1'b0, 1'b0, 1'b0, 0, -1);  // xor
    run_instr(7'b0110011, 3'd1, 1'b0, 1'b0, 1'b0, 0, -1);  // sll
    run_instr(7'b0010011, 3'd0, 1'b1, 1'b0, 1'b0, 0, -1);  // addi, imm bit 30 set
    run_instr(7'b1100011, 3'd0, 1'b0, 1'b1, 1'b0, 0, -1);  // beq taken
    run_instr(7'b1100011, 3'd0, 1'b0, 1'b0, 1'b0, 0, -1);  // beq not taken
    run_instr(7'b1100011, 3'd4, 1'b0, 1'b0, 1'b1, 0, -1);  // blt taken
    run_instr(7'b1100011, 3'd5, 1'b0, 1'b0, 1'b1, 0, -1);  // bge not taken
    run_instr(7'b1101111, 3'd0, 1'b0, 1'b0, 1'b0, 0, -1);  // jal
    run_instr(7'b0110111, 3'd0, 1'b0, 1'b0, 1'b0, 10, -1); // lui: unsupported
    run_instr(7'b0110011, 3'd2, 1'b0, 1'b0, 1'b0, 10, -1); // slt: unsupported
    run_instr(7'b0010011, 3'd5, 1'b1, 1'b0, 1'b0, 2, -1);  // srai: unsupported

    for (int n = 0; n < 200; n++) begin
      pick = $urandom_range(0, 7);
      case (pick)
        0:       op = 7'b0000011;
        1:       op = 7'b0100011;
        2, 7:    op = 7'b0110011;
        3:       op = 7'b0010011;
        4:       op = 7'b1100011;
        5:       op = 7'b1101111;
        default: op = 7'($urandom_range(0, 127));
      endcase
      run_instr(op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(1, 4), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
